fsm_bus_arbiter: RTL and testbench
==================================

Name: fsm_bus_arbiter

Overview:
- Bus-side responder for the one-hot req/gnt/done/dly bus handshake used by our requester FSMs.
- Accepts requests from N requesters and grants the bus to exactly one of them at a time, with round-robin priority.
- Holds the grant until the owner signals done, and stretches it while the owner asserts dly.
- Sits between the requester FSMs and the shared bus mux; the owner output drives the mux select.

Parameters:
- N, 4, number of requesters (2..16).
- IDW, 2, width of owner index; must satisfy 2**IDW >= N.
- TMO_CYC, 255, watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- req  input  N  bus request, one bit per requester; level, held until granted.
- done  input  N  transfer-complete flag from each requester; only the owner's bit is sampled.
- dly  input  N  delay/extend flag from each requester; only the owner's bit is sampled.
- gnt  output  N  registered one-hot grant; all zero when the bus is free.
- owner  output  IDW  index of the current or last grantee.
- busy  output  1  high while in BBUSY or BWAIT.
- tmo  output  1  one-cycle watchdog pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- State register: 4-bit one-hot, with states IDLE, BBUSY, BWAIT, BFREE. All outputs are registered.
- Reset (rst_n low at a clk edge):
  - state = IDLE; gnt = 0; owner = 0; busy = 0; tmo = 0.
  - Round-robin pointer ptr = 0.
  - Reset mid-transfer drops gnt on the same edge.
- Winner selection: the first requester with req set, scanning from index ptr upward with wrap N-1 -> 0.
- IDLE:
  - If any req is set: gnt[w] = 1, owner = w, go to BBUSY.
  - Otherwise stay in IDLE.
  - Latency: req sampled at edge k, gnt visible after edge k.
- BBUSY (gnt held):
  - done[owner] = 0: stay in BBUSY.
  - done = 1 and dly = 1: go to BWAIT.
  - done = 1 and dly = 0: go to BFREE.
- BWAIT (gnt held): dly[owner] = 0 -> BFREE; otherwise stay in BWAIT.
- BFREE:
  - gnt = 0 for exactly one cycle (turnaround).
  - ptr = owner + 1, wrapping to 0 when owner = N-1; use an explicit compare, never a modulo on N.
  - Next state: BBUSY with a new winner (chosen using the updated ptr) if any req is set; otherwise IDLE.
  - Back-to-back grants are therefore separated by exactly one idle cycle.
- Non-owner signals: done and dly from non-owners are ignored in every state.
- Owner dropping req while granted: ignored. The grant ends only through done (or timeout).
- Simultaneous requests: exactly one grant is issued. The others wait, and each gets the bus within N grants (no starvation).
- Illegal (non-one-hot) state: next state is IDLE, gnt = 0.
- Invariant: popcount(gnt) <= 1 in every cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on entry to BBUSY and increments in BBUSY and BWAIT.
  - When the counter equals TMO_CYC, the FSM is forced to BFREE: gnt drops on the next edge, tmo pulses high for 1 cycle, and ptr advances as normal.
  - done/dly arriving on the same cycle as the timeout are ignored.
- When not defined: no counter is built, tmo is constant 0, and a grant can be held indefinitely.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with req = 4'b1111 -> gnt = 0, owner = 0, busy = 0. After release, gnt = 4'b0001 one cycle later.
- Single transfer: req = 4'b0100 -> gnt = 4'b0100, owner = 2. Pulse done[2] after 5 cycles -> gnt = 0 next cycle (BFREE), then IDLE.
- Delay stretch: owner 1 asserts done and dly together and holds dly for 4 cycles -> gnt stays 4'b0010 for those 4 cycles, then drops one cycle after dly falls.
- Round robin: req = 4'b1111 held, each owner pulses done once -> grant order 0, 1, 2, 3, 0, each separated by one zero-gnt cycle.
- Foreign signals and req drop: done[3] = 1 while owner = 0 -> no effect. Owner drops req mid-BBUSY -> gnt held until done[0].
- Timeout (ARB_TIMEOUT_EN, TMO_CYC = 10): owner never asserts done -> gnt drops after 10 granted cycles, tmo high for 1 cycle, next requester is granted.

Source files
------------

// File: rtl/fsm_bus_arbiter.sv
// fsm_bus_arbiter: round-robin one-hot bus arbiter for the req/gnt/done/dly handshake.
// Optional watchdog is built when ARB_TIMEOUT_EN is defined (limit TMO_CYC).
module fsm_bus_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TMO_CYC = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  input  logic [N-1:0]   dly,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] owner,
  output logic           busy,
  output logic           tmo
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    BBUSY = 4'b0010,
    BWAIT = 4'b0100,
    BFREE = 4'b1000
  } state_t;

  state_t         state_r, state_s;
  logic [N-1:0]   gnt_r, gnt_s;
  logic [IDW-1:0] owner_r, owner_s;
  logic [IDW-1:0] ptr_r, ptr_s;
  logic [IDW-1:0] nxt_ptr_s, scan_s;
  logic [IDW:0]   pick_s;
  logic           busy_r, busy_s;
  logic           tmo_r, tmo_s;
  logic           tmo_hit_s;
  logic           own_done_s, own_dly_s;

  // First set bit of r at or above start, wrapping N-1 -> 0; MSB flags a hit.
  function automatic logic [IDW:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] start);
    logic [IDW:0] res;
    int           k;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(start) + i;
      if (k >= N) begin
        k = k - N;
      end else begin
        k = k;
      end
      if (r[k]) begin
        res = {1'b1, IDW'(k)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
    logic [N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  assign own_done_s = done[owner_r];
  assign own_dly_s  = dly[owner_r];
  assign nxt_ptr_s  = (owner_r == IDW'(N - 1)) ? {IDW{1'b0}} : owner_r + IDW'(1);
  // In BFREE the winner is chosen from the freshly advanced pointer.
  assign scan_s     = (state_r == BFREE) ? nxt_ptr_s : ptr_r;
  assign pick_s     = pick(req, scan_s);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_r;

  // Watchdog counter: cleared on entry to BBUSY, counts while the grant is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (state_s == BBUSY && state_r != BBUSY) begin
      cnt_r <= 16'd0;
    end else if (state_r == BBUSY || state_r == BWAIT) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tmo_hit_s = (state_r == BBUSY || state_r == BWAIT) &&
                     ((cnt_r + 16'd1) == 16'(TMO_CYC));
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    tmo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s[IDW]) begin
          state_s = BBUSY;
          gnt_s   = onehot(pick_s[IDW-1:0]);
          owner_s = pick_s[IDW-1:0];
        end else begin
          state_s = IDLE;
          gnt_s   = '0;
        end
      end
      BBUSY: begin
        if (tmo_hit_s) begin
          state_s = BFREE;
          gnt_s   = '0;
          tmo_s   = 1'b1;
        end else if (own_done_s && own_dly_s) begin
          state_s = BWAIT;
        end else if (own_done_s) begin
          state_s = BFREE;
          gnt_s   = '0;
        end else begin
          state_s = BBUSY;
        end
      end
      BWAIT: begin
        if (tmo_hit_s) begin
          state_s = BFREE;
          gnt_s   = '0;
          tmo_s   = 1'b1;
        end else if (!own_dly_s) begin
          state_s = BFREE;
          gnt_s   = '0;
        end else begin
          state_s = BWAIT;
        end
      end
      BFREE: begin
        ptr_s = nxt_ptr_s;
        if (pick_s[IDW]) begin
          state_s = BBUSY;
          gnt_s   = onehot(pick_s[IDW-1:0]);
          owner_s = pick_s[IDW-1:0];
        end else begin
          state_s = IDLE;
          gnt_s   = '0;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
      end
    endcase
    busy_s = (state_s == BBUSY) || (state_s == BWAIT);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      owner_r <= '0;
      ptr_r   <= '0;
      busy_r  <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      busy_r  <= busy_s;
      tmo_r   <= tmo_s;
    end
  end

  assign gnt   = gnt_r;
  assign owner = owner_r;
  assign busy  = busy_r;
  assign tmo   = tmo_r;

endmodule

// File: tb/tb_fsm_bus_arbiter.sv
// tb_fsm_bus_arbiter: table-driven directed checks of fsm_bus_arbiter (N=4),
// plus hand-written long-hold / watchdog (ARB_TIMEOUT_EN) sequences.
module tb_fsm_bus_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, done, dly;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] owner;
  logic           busy, tmo;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   dly;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] owner;
    logic           busy;
  } vec_t;

  vec_t tbl[$];

  fsm_bus_arbiter #(.N(N), .IDW(IDW), .TMO_CYC(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .done (done),
    .dly  (dly),
    .gnt  (gnt),
    .owner(owner),
    .busy (busy),
    .tmo  (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] d, input logic [3:0] y,
                     input logic [3:0] g, input logic [1:0] o, input logic b);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d; v.dly = y;
    v.gnt = g; v.owner = o; v.busy = b;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] d, input logic [3:0] y);
    @(negedge clk);
    rst_n = r; req = q; done = d; dly = y;
    @(posedge clk);
    #1;
  endtask

  // At most one grant in any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot", 0, 32'($countones(gnt) <= 1), 32'd1);
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; req = '0; done = '0; dly = '0;

    // reset with all requests pending
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 2'd0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 2'd0, 0);
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 2'd0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 4'h1, 2'd0, 1);
    // round robin 0,1,2,3,0 with one free cycle between grants
    add(1, 4'hF, 4'h1, 4'h0, 4'h0, 2'd0, 0);
    add(1, 4'hF, 4'h0, 4'h0, 4'h2, 2'd1, 1);
    add(1, 4'hF, 4'h2, 4'h0, 4'h0, 2'd1, 0);
    add(1, 4'hF, 4'h0, 4'h0, 4'h4, 2'd2, 1);
    add(1, 4'hF, 4'h4, 4'h0, 4'h0, 2'd2, 0);
    add(1, 4'hF, 4'h0, 4'h0, 4'h8, 2'd3, 1);
    add(1, 4'hF, 4'h8, 4'h0, 4'h0, 2'd3, 0);
    add(1, 4'hF, 4'h0, 4'h0, 4'h1, 2'd0, 1);
    // foreign done/dly ignored, owner drops req but keeps the bus
    add(1, 4'hF, 4'h8, 4'h8, 4'h1, 2'd0, 1);
    add(1, 4'hE, 4'h0, 4'h0, 4'h1, 2'd0, 1);
    add(1, 4'h0, 4'h0, 4'h0, 4'h1, 2'd0, 1);
    add(1, 4'h0, 4'h1, 4'h0, 4'h0, 2'd0, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
    // single transfer to requester 2 (ptr=1), dly without done is ignored
    add(1, 4'h4, 4'h0, 4'h0, 4'h4, 2'd2, 1);
    add(1, 4'h4, 4'h0, 4'h4, 4'h4, 2'd2, 1);
    add(1, 4'h4, 4'h0, 4'h0, 4'h4, 2'd2, 1);
    add(1, 4'h4, 4'h0, 4'h0, 4'h4, 2'd2, 1);
    add(1, 4'h4, 4'h0, 4'h0, 4'h4, 2'd2, 1);
    add(1, 4'h4, 4'h0, 4'h0, 4'h4, 2'd2, 1);
    add(1, 4'h4, 4'h4, 4'h0, 4'h0, 2'd2, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd2, 0);
    // delay stretch on owner 1 (ptr=3 wraps to 1)
    add(1, 4'h2, 4'h0, 4'h0, 4'h2, 2'd1, 1);
    add(1, 4'h2, 4'h2, 4'h2, 4'h2, 2'd1, 1);
    add(1, 4'h0, 4'h0, 4'h2, 4'h2, 2'd1, 1);
    add(1, 4'h0, 4'h0, 4'h2, 4'h2, 2'd1, 1);
    add(1, 4'h0, 4'h0, 4'h2, 4'h2, 2'd1, 1);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd1, 0);
    // ptr=2 picks 3, then wrap to 0 back-to-back
    add(1, 4'h9, 4'h0, 4'h0, 4'h8, 2'd3, 1);
    add(1, 4'h9, 4'h8, 4'h0, 4'h0, 2'd3, 0);
    add(1, 4'h1, 4'h0, 4'h0, 4'h1, 2'd0, 1);
    add(1, 4'h1, 4'h1, 4'h0, 4'h0, 2'd0, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
    // reset mid-transfer drops the grant on the same edge
    add(1, 4'h4, 4'h0, 4'h0, 4'h4, 2'd2, 1);
    add(0, 4'h4, 4'h0, 4'h0, 4'h0, 2'd0, 0);
    add(1, 4'h4, 4'h0, 4'h0, 4'h4, 2'd2, 1);
    add(1, 4'h4, 4'h4, 4'h0, 4'h0, 2'd2, 0);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].req, tbl[i].done, tbl[i].dly);
      mon_en = 1'b1;
      chk("gnt",   i, 32'(gnt),   32'(tbl[i].gnt));
      chk("owner", i, 32'(owner), 32'(tbl[i].owner));
      chk("busy",  i, 32'(busy),  32'(tbl[i].busy));
      chk("tmo",   i, 32'(tmo),   32'd0);
    end

    // Now IDLE with ptr=3: requester 3 wins first.
    drive(1'b1, 4'h9, 4'h0, 4'h0);
    chk("hold_first", 0, 32'(gnt), 32'h8);
`ifdef ARB_TIMEOUT_EN
    n = 1;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 4'h9, 4'h0, 4'h0);
      if (gnt == 4'h8) n++;
      else break;
    end
    chk("tmo_len", 0, 32'(n), 32'(TMO));
    chk("tmo_gnt", 0, 32'(gnt), 32'h0);
    chk("tmo_pulse", 0, 32'(tmo), 32'd1);
    drive(1'b1, 4'h9, 4'h0, 4'h0);
    chk("tmo_next", 0, 32'(gnt), 32'h1);
    chk("tmo_end", 0, 32'(tmo), 32'd0);
    chk("tmo_owner", 0, 32'(owner), 32'd0);
`else
    n = 0;
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, 4'h9, 4'h0, 4'h0);
      if (gnt == 4'h8 && tmo == 1'b0) n++;
    end
    chk("hold_len", 0, 32'(n), 32'd30);
    drive(1'b1, 4'h9, 4'h8, 4'h0);
    chk("hold_rel", 0, 32'(gnt), 32'h0);
    drive(1'b1, 4'h1, 4'h0, 4'h0);
    chk("hold_next", 0, 32'(gnt), 32'h1);
    chk("hold_owner", 0, 32'(owner), 32'd0);
`endif
    drive(1'b1, 4'h0, 4'h1, 4'h0);
    chk("final_rel", 0, 32'(gnt), 32'h0);
    drive(1'b1, 4'h0, 4'h0, 4'h0);
    chk("final_idle", 0, 32'(busy), 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
